// File: rtl/dataram_pkg.sv
// -----------------------------------------------------------------------------
// dataram_pkg
// Shared definitions for the data-RAM arbiter slice.
//   ADDR_W_DEF / DATA_W_DEF : default RAM address / word widths
//   arb_state_t             : arbiter states (free, held by port 0, held by port 1)
//   PORT0 / PORT1           : requester index constants (CPU data, I/O-DMA)
// -----------------------------------------------------------------------------
package dataram_pkg;

    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        HOLD0 = 2'd1,
        HOLD1 = 2'd2
    } arb_state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/dataram_rr_pick.sv
// -----------------------------------------------------------------------------
// dataram_rr_pick
// Combinational two-way round-robin picker with an optional held owner.
//   req[1:0]    in  : request vector, bit i = port i
//   last_grant  in  : port that made the most recent transfer
//   hold_valid  in  : a locked owner currently holds the RAM
//   hold_idx    in  : index of that owner
//   grant[1:0]  out : one-hot grant (all zero when nobody requests)
// -----------------------------------------------------------------------------
module dataram_rr_pick
    import dataram_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       hold_valid,
    input  logic       hold_idx,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (hold_valid && req[hold_idx]) begin
            // A holder still requesting keeps the RAM whatever the other port does.
            grant[hold_idx] = 1'b1;
        end else if (req == 2'b11) begin
            // Tie: the port that did not transfer last wins.
            grant = (last_grant == PORT0) ? 2'b10 : 2'b01;
        end else begin
            // Zero or one requester; a holder that dropped its request falls
            // through here in the same cycle, so there is no idle bubble.
            grant = req;
        end
    end

endmodule

// File: rtl/dataram_arbiter.sv
// -----------------------------------------------------------------------------
// dataram_arbiter
// Shares one single-port data RAM (synchronous write, combinational read)
// between the CPU data port (0) and the I/O / DMA port (1). Round-robin with
// an optional lock that keeps the RAM for up to MAX_BURST consecutive
// transfers. Read data is registered per port with a one-cycle rvalid pulse.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   reqN/weN/addrN/wdataN/lockN: requester N command (held until readyN)
//   readyN                     : grant, transfer at edge where reqN & readyN
//   rvalidN/rdataN             : registered read return, one cycle after edge
//   ram_addr/ram_wdata/ram_we  : to RAM
//   ram_rdata                  : from RAM (combinational)
// -----------------------------------------------------------------------------
module dataram_arbiter
    import dataram_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              lock0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock1,
    output logic              ready0,
    output logic              ready1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t       state_reg, state_next;
    logic             last_grant_reg, last_grant_next;
    logic [CNT_W-1:0] burst_cnt_reg, burst_cnt_next;
    logic [CNT_W-1:0] cnt_new;
    logic             held_by_xfer;

    logic [1:0] req_vec, we_vec, lock_vec;
    logic [1:0] grant_raw, ready_vec, xfer_vec;
    logic       xfer_idx;

    logic              rvalid_reg [2];
    logic [DATA_W-1:0] rdata_reg  [2];

    assign req_vec  = {req1, req0};
    assign we_vec   = {we1, we0};
    assign lock_vec = {lock1, lock0};

    dataram_rr_pick u_pick (
        .req        (req_vec),
        .last_grant (last_grant_reg),
        .hold_valid (state_reg != ARB),
        .hold_idx   (state_reg == HOLD1),
        .grant      (grant_raw)
    );

    // Gating by rst_n makes ready and ram_we drop the instant reset is
    // asserted, even between clock edges, so no write slips into the RAM.
    assign ready_vec = grant_raw & {2{rst_n}};
    assign xfer_vec  = ready_vec & req_vec;
    assign xfer_idx  = xfer_vec[PORT1];

    assign ready0 = ready_vec[PORT0];
    assign ready1 = ready_vec[PORT1];

    // Idle default routes port 0 so the RAM sees a stable address.
    assign ram_addr  = ready_vec[PORT1] ? addr1  : addr0;
    assign ram_wdata = ready_vec[PORT1] ? wdata1 : wdata0;
    assign ram_we    = |(ready_vec & we_vec);

    // ------------------------------------------------------------------ FSM
    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        burst_cnt_next  = burst_cnt_reg;

        // Continuing a burst only when the same port already holds the RAM;
        // any other transfer starts a fresh count at 1.
        held_by_xfer = xfer_idx ? (state_reg == HOLD1) : (state_reg == HOLD0);
        cnt_new      = held_by_xfer ? (burst_cnt_reg + CNT_W'(1)) : CNT_W'(1);

        if (|xfer_vec) begin
            last_grant_next = xfer_idx;
            if (lock_vec[xfer_idx] && (cnt_new < CNT_W'(MAX_BURST))) begin
                state_next     = xfer_idx ? HOLD1 : HOLD0;
                burst_cnt_next = cnt_new;
            end else begin
                // Burst exhausted (or no lock): the holder is now last_grant,
                // so a waiting other port wins the next tie.
                state_next     = ARB;
                burst_cnt_next = '0;
            end
        end else if (state_reg != ARB) begin
            state_next     = ARB;
            burst_cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ARB;
            last_grant_reg <= PORT1;
            burst_cnt_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            burst_cnt_reg  <= burst_cnt_next;
        end
    end

    // ------------------------------------------------------- read returns
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rvalid_reg[gi] <= 1'b0;
                    rdata_reg[gi]  <= '0;
                end else begin
                    rvalid_reg[gi] <= xfer_vec[gi] & ~we_vec[gi];
                    // Writes leave the last read value untouched.
                    if (xfer_vec[gi] && !we_vec[gi]) begin
                        rdata_reg[gi] <= ram_rdata;
                    end
                end
            end
        end
    endgenerate

    assign rvalid0 = rvalid_reg[0];
    assign rvalid1 = rvalid_reg[1];
    assign rdata0  = rdata_reg[0];
    assign rdata1  = rdata_reg[1];

endmodule

// File: tb/tb_dataram_arbiter.sv
module tb_dataram_arbiter;

    localparam int MAX_BURST = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, we, lock;
    logic [14:0] addr  [2];
    logic [15:0] wdata [2];
    logic        ready0, ready1, rvalid0, rvalid1, ram_we;
    logic [15:0] rdata0, rdata1, ram_wdata, ram_rdata;
    logic [14:0] ram_addr;

    logic [15:0] mem     [0:32767];
    logic [15:0] ref_mem [0:32767];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dataram_arbiter #(.ADDR_W(15), .DATA_W(16), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req[0]), .we0(we[0]), .addr0(addr[0]), .wdata0(wdata[0]), .lock0(lock[0]),
        .req1(req[1]), .we1(we[1]), .addr1(addr[1]), .wdata1(wdata[1]), .lock1(lock[1]),
        .ready0(ready0), .ready1(ready1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    // Environment RAM: synchronous write, combinational read.
    assign ram_rdata = mem[ram_addr];
    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
        forever begin
            @(posedge clk);
            if (ram_we) mem[ram_addr] <= ram_wdata;
        end
    end

    // ---------------------------------------------------------- reference model
    int          holder;     // port currently keeping the RAM, -1 if none
    int          run_len;    // consecutive transfers by holder
    int          last_w;     // port that transferred most recently
    int          eg;         // expected winner this cycle, -1 if none
    logic        exp_rv [2];
    logic [15:0] exp_rd [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick_model();
        if (holder >= 0 && req[holder]) return holder;
        if (req[0] && req[1]) return 1 - last_w;
        if (req[0]) return 0;
        if (req[1]) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        holder = -1; run_len = 0; last_w = 1;
        exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
        exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
    endtask

    task automatic model_check();
        eg = rst_n ? pick_model() : -1;
        chk("ready0", 32'(ready0), 32'(eg == 0));
        chk("ready1", 32'(ready1), 32'(eg == 1));
        chk("ram_we", 32'(ram_we), 32'((eg >= 0) ? we[eg] : 1'b0));
        chk("ram_addr", 32'(ram_addr), 32'((eg == 1) ? addr[1] : addr[0]));
        if (eg >= 0 && we[eg]) chk("ram_wdata", 32'(ram_wdata), 32'(wdata[eg]));
        chk("rvalid0", 32'(rvalid0), 32'(exp_rv[0]));
        chk("rvalid1", 32'(rvalid1), 32'(exp_rv[1]));
        chk("rdata0", 32'(rdata0), 32'(exp_rd[0]));
        chk("rdata1", 32'(rdata1), 32'(exp_rd[1]));
    endtask

    task automatic model_update();
        exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
        if (eg >= 0) begin
            if (we[eg]) begin
                ref_mem[addr[eg]] = wdata[eg];
                $display("xfer port%0d write addr=%h data=%h", eg, addr[eg], wdata[eg]);
            end else begin
                exp_rv[eg] = 1'b1;
                exp_rd[eg] = ref_mem[addr[eg]];
                $display("xfer port%0d read  addr=%h data=%h", eg, addr[eg], ref_mem[addr[eg]]);
            end
            run_len = (eg == holder) ? run_len + 1 : 1;
            last_w  = eg;
            if (lock[eg] && run_len < MAX_BURST) holder = eg;
            else begin holder = -1; run_len = 0; end
        end else begin
            holder = -1; run_len = 0;
        end
    endtask

    task automatic set_idle();
        req = 2'b00; we = 2'b00; lock = 2'b00;
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    endtask

    task automatic tick();
        @(negedge clk); model_check();
        @(posedge clk); model_update();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_idle();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    // ---------------------------------------------------------- vector table
    typedef struct {
        logic        r0, w0, l0; logic [14:0] a0; logic [15:0] d0;
        logic        r1, w1, l1; logic [14:0] a1; logic [15:0] d1;
        logic        g0, g1, v0, v1;
        logic [15:0] q0, q1;
    } vec_t;

    vec_t vt [25];

    function automatic vec_t mk(
        input logic r0, w0, l0, input logic [14:0] a0, input logic [15:0] d0,
        input logic r1, w1, l1, input logic [14:0] a1, input logic [15:0] d1,
        input logic g0, g1, v0, v1, input logic [15:0] q0, q1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.q0 = q0; v.q1 = q1;
        return v;
    endfunction

    task automatic run_vec(input int k);
        req[0] = vt[k].r0; we[0] = vt[k].w0; lock[0] = vt[k].l0; addr[0] = vt[k].a0; wdata[0] = vt[k].d0;
        req[1] = vt[k].r1; we[1] = vt[k].w1; lock[1] = vt[k].l1; addr[1] = vt[k].a1; wdata[1] = vt[k].d1;
        @(negedge clk);
        model_check();
        chk($sformatf("vec%0d ready0", k), 32'(ready0), 32'(vt[k].g0));
        chk($sformatf("vec%0d ready1", k), 32'(ready1), 32'(vt[k].g1));
        chk($sformatf("vec%0d rvalid0", k), 32'(rvalid0), 32'(vt[k].v0));
        chk($sformatf("vec%0d rvalid1", k), 32'(rvalid1), 32'(vt[k].v1));
        if (vt[k].v0) chk($sformatf("vec%0d rdata0", k), 32'(rdata0), 32'(vt[k].q0));
        if (vt[k].v1) chk($sformatf("vec%0d rdata1", k), 32'(rdata1), 32'(vt[k].q1));
        @(posedge clk); model_update();
        #1;
    endtask

    initial begin
        // port 0 write then read-back
        vt[0]  = mk(1,1,0,15'h1376,16'h1111, 0,0,0,15'h0000,16'h0000, 1,0,0,0,16'h0,16'h0);
        vt[1]  = mk(1,0,0,15'h1376,16'h0000, 0,0,0,15'h0000,16'h0000, 1,0,0,0,16'h0,16'h0);
        vt[2]  = mk(0,0,0,15'h0000,16'h0000, 0,0,0,15'h0000,16'h0000, 0,0,1,0,16'h1111,16'h0);
        vt[3]  = mk(0,0,0,15'h0000,16'h0000, 0,0,0,15'h0000,16'h0000, 0,0,0,0,16'h0,16'h0);
        // both ports from reset, alternating
        vt[4]  = mk(1,1,0,15'h1478,16'h2240, 1,1,0,15'h0000,16'h3451, 1,0,0,0,16'h0,16'h0);
        vt[5]  = mk(1,0,0,15'h1478,16'h0000, 1,1,0,15'h0000,16'h3451, 0,1,0,0,16'h0,16'h0);
        vt[6]  = mk(1,0,0,15'h1478,16'h0000, 1,0,0,15'h0000,16'h0000, 1,0,0,0,16'h0,16'h0);
        vt[7]  = mk(1,0,0,15'h1376,16'h0000, 1,0,0,15'h0000,16'h0000, 0,1,1,0,16'h2240,16'h0);
        vt[8]  = mk(1,0,0,15'h1376,16'h0000, 0,0,0,15'h0000,16'h0000, 1,0,0,1,16'h0,16'h3451);
        vt[9]  = mk(0,0,0,15'h0000,16'h0000, 0,0,0,15'h0000,16'h0000, 0,0,1,0,16'h1111,16'h0);
        // port 1 locked burst of MAX_BURST, then port 0
        vt[10] = mk(1,0,0,15'h1478,16'h0000, 1,0,1,15'h0000,16'h0000, 0,1,0,0,16'h0,16'h0);
        vt[11] = mk(1,0,0,15'h1478,16'h0000, 1,0,1,15'h0000,16'h0000, 0,1,0,1,16'h0,16'h3451);
        vt[12] = mk(1,0,0,15'h1478,16'h0000, 1,0,1,15'h0000,16'h0000, 0,1,0,1,16'h0,16'h3451);
        vt[13] = mk(1,0,0,15'h1478,16'h0000, 1,0,1,15'h0000,16'h0000, 0,1,0,1,16'h0,16'h3451);
        vt[14] = mk(1,0,0,15'h1478,16'h0000, 1,0,1,15'h0000,16'h0000, 1,0,0,1,16'h0,16'h3451);
        vt[15] = mk(0,0,0,15'h0000,16'h0000, 1,0,1,15'h0000,16'h0000, 0,1,1,0,16'h2240,16'h0);
        // locked port 0 drops request, port 1 takes over with no bubble
        vt[16] = mk(0,0,0,15'h0000,16'h0000, 0,0,0,15'h0000,16'h0000, 0,0,0,1,16'h0,16'h3451);
        vt[17] = mk(1,0,1,15'h1376,16'h0000, 0,0,0,15'h0000,16'h0000, 1,0,0,0,16'h0,16'h0);
        vt[18] = mk(1,0,1,15'h1376,16'h0000, 1,1,0,15'h0010,16'habcd, 1,0,1,0,16'h1111,16'h0);
        vt[19] = mk(0,0,0,15'h0000,16'h0000, 1,1,0,15'h0010,16'habcd, 0,1,1,0,16'h1111,16'h0);
        vt[20] = mk(0,0,0,15'h0000,16'h0000, 0,0,0,15'h0000,16'h0000, 0,0,0,0,16'h0,16'h0);
        // after mid-write reset: port 0 wins first tie; port 1 read then write
        vt[21] = mk(1,0,0,15'h0000,16'h0000, 1,0,0,15'h1478,16'h0000, 1,0,0,0,16'h0,16'h0);
        vt[22] = mk(0,0,0,15'h0000,16'h0000, 1,0,0,15'h1478,16'h0000, 0,1,1,0,16'h3451,16'h0);
        vt[23] = mk(0,0,0,15'h0000,16'h0000, 1,1,0,15'h1478,16'h7fff, 0,1,0,1,16'h0,16'h2240);
        vt[24] = mk(0,0,0,15'h0000,16'h0000, 0,0,0,15'h0000,16'h0000, 0,0,0,0,16'h0,16'h0);

        for (int i = 0; i < 32768; i++) ref_mem[i] = 16'h0000;
        model_reset();

        // Reset state, with both ports requesting: grants must stay low.
        rst_n = 1'b0;
        set_idle();
        req = 2'b11; we = 2'b11;
        #12;
        chk("rst ready0", 32'(ready0), 32'(0));
        chk("rst ready1", 32'(ready1), 32'(0));
        chk("rst ram_we", 32'(ram_we), 32'(0));
        chk("rst rvalid0", 32'(rvalid0), 32'(0));
        chk("rst rvalid1", 32'(rvalid1), 32'(0));
        chk("rst rdata0", 32'(rdata0), 32'(0));
        chk("rst rdata1", 32'(rdata1), 32'(0));
        do_reset();

        for (int k = 0; k < 4; k++) run_vec(k);
        do_reset();
        for (int k = 4; k < 21; k++) run_vec(k);

        // Reset asserted between edges during a port-0 write of 0xff09 to 0x0000.
        set_idle();
        req[1] = 1'b1; addr[1] = 15'h1478;
        tick();
        set_idle();
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 15'h0000; wdata[0] = 16'hff09;
        #2;
        chk("pre-rst ready0", 32'(ready0), 32'(1));
        chk("pre-rst ram_we", 32'(ram_we), 32'(1));
        chk("pre-rst rvalid1", 32'(rvalid1), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("mid-rst ready0", 32'(ready0), 32'(0));
        chk("mid-rst ram_we", 32'(ram_we), 32'(0));
        chk("mid-rst rvalid1", 32'(rvalid1), 32'(0));
        chk("mid-rst rdata1", 32'(rdata1), 32'(0));
        @(posedge clk);
        #1;
        chk("mid-rst mem0", 32'(mem[0]), 32'(16'h3451));
        chk("mid-rst ready0 held", 32'(ready0), 32'(0));
        set_idle();
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;

        for (int k = 21; k < 25; k++) run_vec(k);
        chk("rdata1 after write", 32'(rdata1), 32'(16'h2240));
        chk("mem 1478", 32'(mem[15'h1478]), 32'(16'h7fff));

        // Randomized traffic on a small address window against the model.
        set_idle();
        for (int c = 0; c < 400; c++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                if (!req[p] || eg == p) begin
                    req[p]   = ($urandom_range(0, 3) != 0);
                    we[p]    = $urandom_range(0, 1) == 1;
                    lock[p]  = $urandom_range(0, 1) == 1;
                    addr[p]  = 15'($urandom_range(0, 7));
                    wdata[p] = 16'($urandom);
                end
            end
        end
        set_idle();
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dataram_arbiter.md
Name: dataram_arbiter

Overview:
- Shares the single-port data memory RAM (15-bit address, 16-bit word, synchronous write, combinational read) between two requesters.
- Port 0 is the CPU data port; port 1 is the I/O/DMA port (screen refresh, keyboard writer).
- Round-robin arbitration with an optional bounded lock (burst).
- Registers read data per requester, with a one-cycle-later rvalid pulse.

Parameters:
- ADDR_W, 15, RAM address width
- DATA_W, 16, RAM word width
- MAX_BURST, 4, max consecutive transfers a locked requester keeps the RAM (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  request valid; held until transfer
- we0 / we1  in  1  1=write, 0=read
- addr0 / addr1  in  ADDR_W  word address
- wdata0 / wdata1  in  DATA_W  write data
- lock0 / lock1  in  1  request to keep grant for following transfers
- ready0 / ready1  out  1  grant; transfer occurs at edge where reqN&readyN
- rvalid0 / rvalid1  out  1  one-cycle pulse, read data valid
- rdata0 / rdata1  out  DATA_W  registered read data
- ram_addr  out  ADDR_W  to RAM Address
- ram_wdata  out  DATA_W  to RAM data_in
- ram_we  out  1  to RAM writeEn
- ram_rdata  in  DATA_W  from RAM data_out (combinational)

Behaviour:
- Reset (async, rst_n=0):
  - state=ARB, last_grant=1 (port 0 favoured first), burst_cnt=0.
  - rvalid0/1=0, rdata0/1=0.
  - ready0/1 and ram_we forced 0 combinationally while rst_n=0.
- States: ARB, HOLD0, HOLD1.
- Grant (combinational, from registered state):
  - ARB: single requester wins. Both requesting → port != last_grant wins.
  - HOLDi with reqi=1: port i granted regardless of other port.
  - HOLDi with reqi=0: arbitrate exactly as ARB in same cycle (no bubble).
- RAM mux:
  - ram_addr/ram_wdata = granted port's addr/wdata.
  - ram_we = granted & we. No grant → ram_addr/ram_wdata from port 0, ram_we=0.
- Transfer at edge with reqi&readyi:
  - Write is committed by the RAM at that same edge.
  - Read: rdatai <= ram_rdata at that edge; rvalidi=1 for the following cycle only.
  - rdatai holds until the next read on port i; writes never change rdata or rvalid.
- State update on transfer by port i:
  - last_grant <= i.
  - From ARB (or HOLD of the other port): burst_cnt <= 1.
  - From HOLDi: burst_cnt <= burst_cnt+1.
  - Next state = HOLDi if locki=1 and the new burst_cnt < MAX_BURST. Otherwise ARB with burst_cnt <= 0.
- No transfer in cycle:
  - In ARB: stay.
  - In HOLDi with reqi=0 and no other transfer: go to ARB, burst_cnt <= 0.
- MAX_BURST=1: lock has no effect.
- Burst expiry: the holder becomes last_grant, so a waiting other port wins next. With no other request, the holder is re-granted through ARB.
- Latency:
  - Grant: same cycle as req when free.
  - Read data: rvalid one cycle after transfer edge.
  - Worst-case wait for an unlocked requester: MAX_BURST transfers.
- Simultaneous: both req, both lock, from reset → port 0 first.
- Reset mid-operation: in-flight rvalid cleared; lock and burst abandoned; no RAM write on any edge while rst_n=0.
- burst_cnt width: clog2(MAX_BURST+1); never wraps.

Decomposition:
- Package dataram_pkg:
  - ADDR_W/DATA_W defaults
  - state enum (ARB, HOLD0, HOLD1)
  - port index constants
- Sub-module dataram_rr_pick: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last_grant, hold_valid, hold_idx.
  - Outputs: grant[1:0].

Test Plan:
- Port 0 write addr 0x1376 data 0x1111, then read 0x1376:
  - ready0 same cycle as each req.
  - rvalid0 pulse one cycle after the read edge, rdata0=0x1111.
  - Port 1 idle throughout.
- Both ports req from reset, no lock:
  - port0 writes 0x1478←0x2240, port1 writes 0x0000←0x3451 → grants alternate 0,1,0,1.
  - Both later read back correct values.
- Port 1 lock=1 with continuous req, port 0 requesting, MAX_BURST=4:
  - Exactly 4 consecutive port-1 transfers, then port 0 granted.
- Locked port 0 drops req mid-burst while port 1 requests:
  - Port 1 granted in that same cycle.
  - No idle cycle.
- rst_n asserted low between clock edges during a port-0 write of 0xff09 to 0x0000:
  - ready/ram_we drop immediately; RAM[0] keeps its old value.
  - rvalid=0; after release port 0 wins the first tie.
- Port 1 read of 0x1478 followed by a port-1 write of 0x7fff:
  - rdata1 stays 0x2240 and no rvalid1 on the write.
